// File: rtl/mod_final_adder_pkg.sv
// Shared definitions for the final modular-adder stage: default sizes, the 2M
// compare constant and a reference correction function.
package mod_pkg;

  localparam int MOD_W  = 4;
  localparam int MOD_M  = 13;
  localparam int SUM_W  = MOD_W + 2;
  localparam int MOD_2M = 2 * MOD_M;

  typedef struct packed {
    logic        err;
    logic [31:0] r;
  } corr_t;

  // Single conditional subtraction: valid only for s < 2m, flagged otherwise.
  function automatic corr_t mod_correct(input int unsigned s, input int unsigned m);
    corr_t c;
    c.err = 1'b0;
    c.r   = '0;
    if (s < m) begin
      c.r = s;
    end else if (s < 2 * m) begin
      c.r = s - m;
    end else begin
      c.err = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/mod_final_adder_if.sv
// Handshake bundle between stage 2, the final adder stage and its consumer.
interface mod_final_adder_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             err_sticky;
  logic             err_clr;

  modport master (
    output in_valid, a, b, out_ready, err_clr,
    input  in_ready, out_valid, out_data, out_err, err_sticky
  );

  modport slave (
    input  in_valid, a, b, out_ready, err_clr,
    output in_ready, out_valid, out_data, out_err, err_sticky
  );
endinterface

// File: rtl/mod_final_adder_cpa.sv
// Parameterised carry-propagate adder used by the capture stage.
module mod_cpa #(
  parameter int W = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/mod_final_adder.sv
// Final modular adder stage: P1 captures S = a + 2b, P2 folds S into [0, M)
// with one conditional subtract; 2-deep valid/ready pipe with full backpressure.
module mod_final_adder
  import mod_pkg::*;
#(
  parameter int WIDTH   = MOD_W,
  parameter int MODULUS = MOD_M
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mod_final_adder_if.slave     bus
);

  localparam int S_W = WIDTH + 2;
  localparam logic [S_W-1:0] M_S  = S_W'(MODULUS);
  localparam logic [S_W-1:0] M2_S = S_W'(2 * MODULUS);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH) - 1) begin : g_bad_modulus
    $error("mod_final_adder: MODULUS out of range for WIDTH");
  end

  logic             p1_valid;
  logic [S_W-1:0]   p1_sum;
  logic             p2_valid;
  logic             p1_adv;
  logic             p2_adv;
  logic [S_W-1:0]   sum_next;
  logic [WIDTH-1:0] corr_data;
  logic             corr_err;

  // Ready depends only on registered valids and out_ready, never on in_valid.
  assign p2_adv      = !p2_valid || bus.out_ready;
  assign p1_adv      = !p1_valid || p2_adv;
  assign bus.in_ready  = p1_adv;
  assign bus.out_valid = p2_valid;

  mod_cpa #(.W(S_W)) u_cpa (
    .a   (S_W'(bus.a)),
    .b   ({1'b0, bus.b, 1'b0}),
    .sum (sum_next)
  );

  // Low W bits of S-M are exact modulo 2**W, so a W-bit subtract suffices.
  always_comb begin
    corr_data = p1_sum[WIDTH-1:0];
    corr_err  = 1'b0;
    if (p1_sum >= M2_S) begin
      corr_data = '0;
      corr_err  = 1'b1;
    end else if (p1_sum >= M_S) begin
      corr_data = p1_sum[WIDTH-1:0] - WIDTH'(MODULUS);
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values, which is what makes the P1->P2 hand-off race-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_sum   <= '0;
    end else if (p1_adv) begin
      p1_valid <= bus.in_valid;
      if (bus.in_valid) p1_sum <= sum_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_valid       <= 1'b0;
      bus.out_data   <= '0;
      bus.out_err    <= 1'b0;
      bus.err_sticky <= 1'b0;
    end else begin
      if (p2_adv) begin
        p2_valid <= p1_valid;
        if (p1_valid) begin
          bus.out_data <= corr_data;
          bus.out_err  <= corr_err;
        end
      end
      // Set takes priority over a coincident clear.
      if (p2_adv && p1_valid && corr_err) bus.err_sticky <= 1'b1;
      else if (bus.err_clr)               bus.err_sticky <= 1'b0;
    end
  end

endmodule
